// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one MEM-stage load/store onto the shared
// data-memory bus (req/ack), aligns store data, extracts/extends load data
// and stalls the pipeline until the access completes or times out.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   mem_req_i       MEM stage presents an access this cycle
//   mem_we_i        1=store, 0=load
//   mem_size_i      00 byte, 01 half, 10/11 word
//   mem_sign_i      sign-extend loads when 1
//   mem_addr_i      byte address
//   mem_wdata_i     right-justified store data
//   mem_rdata_o     aligned/extended load result, valid with mem_done_o
//   mem_done_o      one-cycle completion pulse
//   stall_req_o     hold the pipeline while the access is outstanding
//   timeout_o       one-cycle pulse with mem_done_o when the bus never acked
//   misalign_o      misaligned request rejected (MEM_ALIGN_CHECK_EN only)
//   bus_req_o       bus request, held until ack or timeout
//   bus_we_o        bus write enable
//   bus_addr_o      word-aligned bus address
//   bus_sel_o       big-endian byte lanes (addr 0 -> 4'b1000)
//   bus_wdata_o     store data replicated into the lanes
//   bus_ack_i       bus completes the transfer this cycle
//   bus_rdata_i     bus read data, valid with bus_ack_i
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses in IDLE and expose misalign_o. Without it, low address bits that
// do not matter for the access size are ignored.

module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_sign_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        stall_req_o,
    output logic        timeout_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic             we_q;
    logic             sign_q;
    logic [1:0]       size_q;
    logic [29:0]      waddr_q;
    logic [3:0]       sel_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             to_q;
    logic [CNT_W-1:0] cnt;

    logic             misalign;
    logic             start;
    logic             busy;
    logic [3:0]       sel_d;
    logic [31:0]      wdata_d;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      load_ext;

`ifdef MEM_ALIGN_CHECK_EN
    // Only meaningful in IDLE; elsewhere the request belongs to the
    // access already in flight.
    assign misalign = (state == IDLE) && mem_req_i &&
                      (((mem_size_i == 2'b01) && mem_addr_i[0]) ||
                       (mem_size_i[1] && (mem_addr_i[1:0] != 2'b00)));
    assign misalign_o = misalign;
`else
    assign misalign = 1'b0;
`endif

    assign start = (state == IDLE) && mem_req_i && !misalign;
    assign busy  = (state == BUS);

    // Byte-lane select and store-data replication for the incoming request.
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = mem_wdata_i;
        unique case (1'b1)
            mem_size_i == 2'b00: begin
                wdata_d = {4{mem_wdata_i[7:0]}};
                unique case (mem_addr_i[1:0])
                    2'b00:   sel_d = 4'b1000;
                    2'b01:   sel_d = 4'b0100;
                    2'b10:   sel_d = 4'b0010;
                    default: sel_d = 4'b0001;
                endcase
            end
            mem_size_i == 2'b01: begin
                wdata_d = {2{mem_wdata_i[15:0]}};
                sel_d   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                sel_d   = 4'b1111;
                wdata_d = mem_wdata_i;
            end
        endcase
    end

    // Pull the addressed lane out of the bus word and extend it.
    always_comb begin
        lane_b   = bus_rdata_i[7:0];
        lane_h   = sel_q[3] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        load_ext = bus_rdata_i;
        unique case (sel_q)
            4'b1000: lane_b = bus_rdata_i[31:24];
            4'b0100: lane_b = bus_rdata_i[23:16];
            4'b0010: lane_b = bus_rdata_i[15:8];
            default: lane_b = bus_rdata_i[7:0];
        endcase
        unique case (1'b1)
            size_q == 2'b00:
                load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
            size_q == 2'b01:
                load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
            default:
                load_ext = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            waddr_q <= '0;
            sel_q   <= 4'b0000;
            wdata_q <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        we_q    <= mem_we_i;
                        sign_q  <= mem_sign_i;
                        size_q  <= mem_size_i;
                        waddr_q <= mem_addr_i[31:2];
                        sel_q   <= sel_d;
                        wdata_q <= wdata_d;
                        cnt     <= '0;
                        to_q    <= 1'b0;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority over an expiring timeout.
                    if (bus_ack_i) begin
                        rdata_q <= load_ext;
                        to_q    <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q <= '0;
                        to_q    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    to_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = busy;
    assign bus_we_o    = busy & we_q;
    assign bus_addr_o  = busy ? {waddr_q, 2'b00} : 32'h0;
    assign bus_sel_o   = busy ? sel_q : 4'b0000;
    assign bus_wdata_o = busy ? wdata_q : 32'h0;

    assign mem_done_o  = (state == DONE);
    assign mem_rdata_o = mem_done_o ? rdata_q : 32'h0;
    assign timeout_o   = mem_done_o & to_q;
    assign stall_req_o = start | busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of mem_access_ctrl against a
// per-cycle timeline model derived from the access latency rules.

module tb_mem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_sign_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        stall_req_o;
    logic        timeout_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .mem_req_i(mem_req_i),
        .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i),
        .mem_sign_i(mem_sign_i),
        .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_done_o(mem_done_o),
        .stall_req_o(stall_req_o),
        .timeout_o(timeout_o),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle.
    logic        chk_en = 1'b0;
    logic        e_req, e_stall, e_done, e_to, e_we, e_mis;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_sel;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: lane select from size and address.
    function automatic logic [3:0] m_sel(input logic [1:0] sz,
                                         input logic [31:0] a);
        if (sz == 2'b00) return 4'(1 << (3 - int'(a[1:0])));
        if (sz == 2'b01) return a[1] ? 4'h3 : 4'hC;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                            input logic [31:0] w);
        if (sz == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (sz == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz,
                                           input logic sg,
                                           input logic [31:0] a,
                                           input logic [31:0] rd);
        int sh;
        logic [31:0] v;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(a[1:0]));
            v  = (rd >> sh) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 0 : 16;
            v  = (rd >> sh) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus_req", {31'h0, bus_req_o}, {31'h0, e_req});
            chk("stall", {31'h0, stall_req_o}, {31'h0, e_stall});
            chk("done", {31'h0, mem_done_o}, {31'h0, e_done});
            chk("timeout", {31'h0, timeout_o}, {31'h0, e_to});
`ifdef MEM_ALIGN_CHECK_EN
            chk("misalign", {31'h0, misalign_o}, {31'h0, e_mis});
`endif
            if (e_req) begin
                chk("bus_we", {31'h0, bus_we_o}, {31'h0, e_we});
                chk("bus_addr", bus_addr_o, e_addr);
                chk("bus_sel", {28'h0, bus_sel_o}, {28'h0, e_sel});
                chk("bus_wdata", bus_wdata_o, e_wdata);
            end
            if (e_done) chk("mem_rdata", mem_rdata_o, e_rdata);
        end
    end

    task automatic exp_idle();
        e_req = 0; e_stall = 0; e_done = 0; e_to = 0; e_mis = 0;
    endtask

    task automatic idle(input logic ack);
        @(posedge clk); #1;
        mem_req_i = 0;
        bus_ack_i = ack;
        bus_rdata_i = $urandom;
        exp_idle();
        @(negedge clk);
    endtask

    // One access; waits<0 means the bus never acks. Reports what was
    // observed so callers can pin it against hand-computed literals.
    task automatic access(input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waits,
                          output logic [3:0] o_sel,
                          output logic [31:0] o_rd,
                          output int o_done, output int o_stall,
                          output int o_req, output logic o_to);
        int nb;
        nb = (waits < 0) ? TO : waits + 1;
        o_sel = 0; o_rd = 0; o_done = -1; o_stall = 0; o_req = 0; o_to = 0;
        for (int c = 0; c <= nb + 1; c++) begin
            @(posedge clk); #1;
            mem_req_i   = 1;
            mem_we_i    = we;
            mem_size_i  = sz;
            mem_sign_i  = sg;
            mem_addr_i  = a;
            mem_wdata_i = wd;
            bus_ack_i   = 0;
            bus_rdata_i = $urandom;
            exp_idle();
            if (c == 0) begin
                e_stall = 1;
            end else if (c <= nb) begin
                e_req   = 1;
                e_stall = 1;
                e_we    = we;
                e_addr  = {a[31:2], 2'b00};
                e_sel   = m_sel(sz, a);
                e_wdata = m_wdata(sz, wd);
                if (waits >= 0 && c == waits + 1) begin
                    bus_ack_i   = 1;
                    bus_rdata_i = rd;
                end
            end else begin
                // Completion cycle; a stray ack here must be ignored.
                bus_ack_i = 1;
                e_done  = 1;
                e_to    = (waits < 0);
                e_rdata = (waits < 0) ? 32'h0 : m_load(sz, sg, a, rd);
            end
            @(negedge clk);
            if (stall_req_o) o_stall++;
            if (bus_req_o) o_req++;
            if (c == 1) o_sel = bus_sel_o;
            if (mem_done_o && o_done < 0) begin
                o_done = c;
                o_rd   = mem_rdata_o;
                o_to   = timeout_o;
            end
        end
        idle(0);
    endtask

    logic [3:0]  s;
    logic [31:0] r;
    int          dc, sc, rc;
    logic        t;

    initial begin
        rst = 1; mem_req_i = 0; mem_we_i = 0; mem_size_i = 0;
        mem_sign_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        bus_ack_i = 0; bus_rdata_i = 0;
        e_we = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_sel = 0;
        exp_idle();
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        idle(0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);

        // Store word, zero-wait ack.
        access(1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, s, r, dc, sc, rc, t);
        chk("sw_sel", {28'h0, s}, 32'hF);
        chk("sw_done_cyc", dc, 2);
        chk("sw_stall_cyc", sc, 2);

        // Load byte signed, three wait cycles.
        access(0, 2'b00, 1, 32'h203, 0, 32'h0000_00F0, 3, s, r, dc, sc, rc, t);
        chk("lb_sel", {28'h0, s}, 32'h1);
        chk("lb_rdata", r, 32'hFFFF_FFF0);
        chk("lb_done_cyc", dc, 5);

        // Load half unsigned, upper address half.
        access(0, 2'b01, 0, 32'h302, 0, 32'h1234_ABCD, 1, s, r, dc, sc, rc, t);
        chk("lhu_sel", {28'h0, s}, 32'h3);
        chk("lhu_rdata", r, 32'h0000_ABCD);

        // Store byte lane 1 and store half lower address.
        access(1, 2'b00, 0, 32'h201, 32'h0000_00A5, 0, 0, s, r, dc, sc, rc, t);
        chk("sb_sel", {28'h0, s}, 32'h4);
        access(1, 2'b01, 0, 32'h200, 32'hFFFF_1234, 0, 2, s, r, dc, sc, rc, t);
        chk("sh_sel", {28'h0, s}, 32'hC);

        // Load half signed, negative; load byte signed, positive.
        access(0, 2'b01, 1, 32'h300, 0, 32'h8001_0000, 0, s, r, dc, sc, rc, t);
        chk("lh_rdata", r, 32'hFFFF_8001);
        access(0, 2'b00, 1, 32'h200, 0, 32'h7F12_3456, 0, s, r, dc, sc, rc, t);
        chk("lb_pos_rdata", r, 32'h0000_007F);

        // Load word with waits.
        access(0, 2'b10, 0, 32'h400, 0, 32'hCAFE_F00D, 2, s, r, dc, sc, rc, t);
        chk("lw_rdata", r, 32'hCAFE_F00D);
        chk("lw_done_cyc", dc, 4);

        // Bus never acks.
        access(0, 2'b10, 0, 32'h500, 0, 0, -1, s, r, dc, sc, rc, t);
        chk("to_req_cyc", rc, 16);
        chk("to_done_cyc", dc, 17);
        chk("to_flag", {31'h0, t}, 32'h1);
        chk("to_rdata", r, 32'h0);

        // Ack on the final allowed cycle wins over the timeout.
        access(0, 2'b10, 0, 32'h504, 0, 32'h1122_3344, 15, s, r, dc, sc, rc, t);
        chk("late_done_cyc", dc, 17);
        chk("late_to_flag", {31'h0, t}, 32'h0);
        chk("late_rdata", r, 32'h1122_3344);

`ifndef MEM_ALIGN_CHECK_EN
        // Without the check, irrelevant low address bits are ignored.
        access(0, 2'b10, 0, 32'h103, 0, 32'h0BAD_F00D, 0, s, r, dc, sc, rc, t);
        chk("lw_unal_sel", {28'h0, s}, 32'hF);
        chk("lw_unal_rdata", r, 32'h0BAD_F00D);
        access(0, 2'b01, 0, 32'h303, 0, 32'h1234_ABCD, 0, s, r, dc, sc, rc, t);
        chk("lh_unal_sel", {28'h0, s}, 32'h3);
`endif

        // Ack while idle is ignored.
        idle(1);
        idle(0);

        // Reset during the second BUS cycle aborts the access.
        @(posedge clk); #1;
        mem_req_i = 1; mem_we_i = 0; mem_size_i = 2'b10;
        mem_addr_i = 32'h600; bus_ack_i = 0;
        exp_idle(); e_stall = 1;
        @(negedge clk);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst = 1;
            exp_idle();
            e_req = 1; e_stall = 1; e_we = 0;
            e_addr = 32'h600; e_sel = 4'hF; e_wdata = 32'h0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 0; mem_req_i = 0;
        exp_idle();
        @(negedge clk);
        chk("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
        idle(0);
        idle(0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load is rejected without touching the bus.
        rc = 0;
        @(posedge clk); #1;
        mem_req_i = 1; mem_we_i = 0; mem_size_i = 2'b10;
        mem_addr_i = 32'h101;
        exp_idle(); e_mis = 1;
        @(negedge clk);
        if (bus_req_o) rc++;
        idle(0);
        if (bus_req_o) rc++;
        idle(0);
        if (bus_req_o) rc++;
        chk("mis_bus_req_cyc", rc, 0);
`endif

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
